// File: rtl/fifo_wptr_full.sv
// Write-domain side of an asynchronous FIFO: binary/Gray write pointer, read-pointer
// synchroniser, and registered full, almost-full, fill-level and sticky-overflow flags.

package fifo_wptr_full_pkg;

  function automatic logic [31:0] b2g(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] g2b(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

module fifo_wptr_full #(
  parameter int DEPTH        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6,
  localparam int A           = $clog2(DEPTH),
  localparam int PW          = A + 1
) (
  input  logic          wclk,
  input  logic          wrst,
  input  logic          winc,
  input  logic [PW-1:0] rptr_gray,
  output logic          wen,
  output logic [A-1:0]  waddr,
  output logic [PW-1:0] wptr_gray,
  output logic          wfull,
  output logic          wafull,
  output logic [PW-1:0] wlevel,
  output logic          woverflow
);

  import fifo_wptr_full_pkg::*;

  logic [PW-1:0] r_sync [SYNC_STAGES];
  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgray;
  logic [PW-1:0] r_wlevel;
  logic          r_wfull;
  logic          r_wafull;
  logic          r_woverflow;

  logic          w_wen;
  logic [PW-1:0] w_wq_rptr;
  logic [PW-1:0] w_wq_bin;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_wlevel_next;
  logic          w_wfull_next;
  logic          w_wafull_next;

  assign w_wq_rptr     = r_sync[SYNC_STAGES-1];
  assign w_wq_bin      = PW'(g2b(32'(w_wq_rptr)));
  assign w_wen         = winc & ~r_wfull;
  assign w_wbin_next   = r_wbin + {{A{1'b0}}, w_wen};
  assign w_wgray_next  = PW'(b2g(32'(w_wbin_next)));
  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
  assign w_wfull_next  = (w_wgray_next == {~w_wq_rptr[A:A-1], w_wq_rptr[A-2:0]});
  assign w_wlevel_next = w_wbin_next - w_wq_bin;
  assign w_wafull_next = (32'(w_wlevel_next) >= 32'(AFULL_THRESH));

  // Read-pointer synchroniser chain into the write clock domain.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= rptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Pointer, flag and sticky-overflow registers.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wbin      <= '0;
      r_wgray     <= '0;
      r_wlevel    <= '0;
      r_wfull     <= 1'b0;
      r_wafull    <= 1'b0;
      r_woverflow <= 1'b0;
    end else begin
      r_wbin      <= w_wbin_next;
      r_wgray     <= w_wgray_next;
      r_wlevel    <= w_wlevel_next;
      r_wfull     <= w_wfull_next;
      r_wafull    <= w_wafull_next;
      r_woverflow <= r_woverflow | (winc & r_wfull);
    end
  end

  assign wen       = w_wen;
  assign waddr     = r_wbin[A-1:0];
  assign wptr_gray = r_wgray;
  assign wfull     = r_wfull;
  assign wafull    = r_wafull;
  assign wlevel    = r_wlevel;
  assign woverflow = r_woverflow;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (DEPTH=8, SYNC_STAGES=2, AFULL_THRESH=6).

module tb_fifo_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       winc;
  logic [3:0] rptr_gray;
  logic       wen;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       wfull;
  logic       wafull;
  logic [3:0] wlevel;
  logic       woverflow;

  int errors = 0;
  int checks = 0;

  fifo_wptr_full #(
    .DEPTH(8),
    .SYNC_STAGES(2),
    .AFULL_THRESH(6)
  ) dut (
    .wclk(wclk),
    .wrst(wrst),
    .winc(winc),
    .rptr_gray(rptr_gray),
    .wen(wen),
    .waddr(waddr),
    .wptr_gray(wptr_gray),
    .wfull(wfull),
    .wafull(wafull),
    .wlevel(wlevel),
    .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic       winc;
    logic [3:0] rptr;
    logic       exp_wen;
    logic [2:0] exp_addr;
    logic [3:0] exp_gray;
    logic       exp_full;
    logic       exp_afull;
    logic [3:0] exp_lvl;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [3:0] gray_of(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [2:0] a, input logic [3:0] g,
                          input logic f, input logic af, input logic [3:0] l, input logic o);
    chk($sformatf("%s.waddr", tag), 32'(waddr), 32'(a));
    chk($sformatf("%s.wptr_gray", tag), 32'(wptr_gray), 32'(g));
    chk($sformatf("%s.wfull", tag), 32'(wfull), 32'(f));
    chk($sformatf("%s.wafull", tag), 32'(wafull), 32'(af));
    chk($sformatf("%s.wlevel", tag), 32'(wlevel), 32'(l));
    chk($sformatf("%s.woverflow", tag), 32'(woverflow), 32'(o));
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    logic [3:0] prev;

    // Fill from empty with rptr=0, one idle cycle, then one dropped write.
    vecs[0] = '{1'b1, 4'h0, 1'b1, 3'd1, 4'b0001, 1'b0, 1'b0, 4'd1, 1'b0};
    vecs[1] = '{1'b1, 4'h0, 1'b1, 3'd2, 4'b0011, 1'b0, 1'b0, 4'd2, 1'b0};
    vecs[2] = '{1'b1, 4'h0, 1'b1, 3'd3, 4'b0010, 1'b0, 1'b0, 4'd3, 1'b0};
    vecs[3] = '{1'b0, 4'h0, 1'b0, 3'd3, 4'b0010, 1'b0, 1'b0, 4'd3, 1'b0};
    vecs[4] = '{1'b1, 4'h0, 1'b1, 3'd4, 4'b0110, 1'b0, 1'b0, 4'd4, 1'b0};
    vecs[5] = '{1'b1, 4'h0, 1'b1, 3'd5, 4'b0111, 1'b0, 1'b0, 4'd5, 1'b0};
    vecs[6] = '{1'b1, 4'h0, 1'b1, 3'd6, 4'b0101, 1'b0, 1'b1, 4'd6, 1'b0};
    vecs[7] = '{1'b1, 4'h0, 1'b1, 3'd7, 4'b0100, 1'b0, 1'b1, 4'd7, 1'b0};
    vecs[8] = '{1'b1, 4'h0, 1'b1, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
    vecs[9] = '{1'b1, 4'h0, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};

    // Reset held with winc=1: everything zero, wen follows winc.
    wrst      = 1'b1;
    winc      = 1'b1;
    rptr_gray = 4'h0;
    #1;
    chk_regs("reset0", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("reset0.wen", 32'(wen), 32'd1);
    step();
    step();
    chk_regs("reset2", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    wrst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      winc      = vecs[i].winc;
      rptr_gray = vecs[i].rptr;
      #1;
      chk($sformatf("vec%0d.wen", i), 32'(wen), 32'(vecs[i].exp_wen));
      step();
      chk_regs($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_gray,
               vecs[i].exp_full, vecs[i].exp_afull, vecs[i].exp_lvl, vecs[i].exp_ovf);
    end

    // Release: one read becomes visible in the flags only after the sync latency.
    winc      = 1'b0;
    rptr_gray = 4'b0001;
    step();
    chk_regs("rel1", 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1);
    step();
    chk_regs("rel2", 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1);
    step();
    chk_regs("rel3", 3'd0, 4'b1100, 1'b0, 1'b1, 4'd7, 1'b1);

    // One more write refills the freed slot and wfull returns immediately.
    winc = 1'b1;
    #1;
    chk("refill.wen", 32'(wen), 32'd1);
    step();
    chk_regs("refill", 3'd1, 4'b1101, 1'b1, 1'b1, 4'd8, 1'b1);
    winc = 1'b0;
    step();
    chk("refill_hold.woverflow", 32'(woverflow), 32'd1);

    // Asynchronous reset in the middle of a cycle clears outputs before any edge.
    #2;
    wrst = 1'b1;
    #1;
    chk_regs("async_rst", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
    rptr_gray = 4'h0;
    step();
    wrst = 1'b0;
    chk_regs("async_rst_edge", 3'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);

    // Wrap: 16 writes with the read pointer trailing by two.
    prev = 4'b0000;
    for (int n = 0; n < 16; n++) begin
      rptr_gray = (n >= 2) ? gray_of(4'(n - 2)) : 4'b0000;
      winc = 1'b1;
      #1;
      chk($sformatf("wrap%0d.wen", n), 32'(wen), 32'd1);
      step();
      chk($sformatf("wrap%0d.hamming", n), 32'($countones(wptr_gray ^ prev)), 32'd1);
      chk($sformatf("wrap%0d.wfull", n), 32'(wfull), 32'd0);
      chk($sformatf("wrap%0d.waddr", n), 32'(waddr), 32'((n + 1) % 8));
      prev = wptr_gray;
    end
    winc = 1'b0;
    chk("wrap.final_gray", 32'(wptr_gray), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
